vram_arbiter: RTL

// - Shares one asynchronous single-port 8-bit SRAM between the video CRT fetch port and the CPU bus.
// - Sits directly upstream of the video CRT controller and serves its VAD / vram_cs / vram_complete fetch handshake.
// - Sequences SRAM strobes over a fixed access window and returns read data to the winning requester.

---
 rtl/vram_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares one asynchronous single-port 8-bit SRAM between the
//               video CRT fetch port and the CPU bus. Each grant runs one SRAM
//               access over a fixed strobe window. Read data is returned to
//               the winner with a 4-phase cs/ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W         SRAM address width (request addresses truncated)
//   ACCESS_CYCLES  clk cycles the strobes are held per access (1..15)
//   MAX_VID_RUN    consecutive video grants before a waiting CPU must win
//                  (used only when the CPU guard is built in)
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   vid_addr/vid_cs                   video fetch request
//   vid_data/vid_complete             video read data and acknowledge
//   cpu_addr/cpu_di/cpu_rw/cpu_cs     CPU request (rw: 1=read, 0=write)
//   cpu_do/cpu_ack                    CPU read data and acknowledge
//   sram_addr/sram_dq_o/sram_dq_oe    SRAM address, write data, data drive
//   sram_dq_i                         SRAM read data
//   sram_ce_n/sram_oe_n/sram_we_n     SRAM strobes, active-low, registered
// Build option
//   VRAM_ARB_CPU_GUARD_EN  when defined, a run counter limits consecutive video
//                          grants while the CPU waits; otherwise video has
//                          strict priority.
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_VID_RUN   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       vid_addr,
  input  logic              vid_cs,
  output logic [7:0]        vid_data,
  output logic              vid_complete,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_di,
  input  logic              cpu_rw,
  input  logic              cpu_cs,
  output logic [7:0]        cpu_do,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_dq_i,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
    $error("vram_arbiter: ACCESS_CYCLES must be in 1..15");
  end
  if (MAX_VID_RUN < 1 || MAX_VID_RUN > 15) begin : g_bad_max_vid_run
    $error("vram_arbiter: MAX_VID_RUN must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VID_RD  = 3'd1,
    CPU_RD  = 3'd2,
    CPU_WR  = 3'd3,
    WR_REC  = 3'd4,
    VID_ACK = 3'd5,
    CPU_ACK = 3'd6
  } state_t;

  // The access counter starts at zero on the grant edge, so the last strobe
  // cycle is the one where it equals ACCESS_CYCLES-1.
  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] acc_cnt;
  logic [3:0] acc_cnt_nx;
  logic       acc_last;
  logic       grant_vid;
  logic       grant_cpu;
  logic       capture_vid;
  logic       capture_cpu;
  logic       cpu_force;

  assign acc_last = (acc_cnt == ACC_LAST);

  // --------------------------------------------------------------------------
  // Optional CPU starvation guard
  // --------------------------------------------------------------------------
`ifdef VRAM_ARB_CPU_GUARD_EN
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_VID_RUN);

  logic [3:0] run_cnt;

  // Only video grants made while the CPU is waiting count towards the limit.
  assign cpu_force = (run_cnt >= RUN_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= 4'd0;
    end else if (grant_cpu) begin
      run_cnt <= 4'd0;
    end else if (grant_vid) begin
      if (!cpu_cs) begin
        run_cnt <= 4'd0;
      end else if (run_cnt != 4'hF) begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end
`else
  assign cpu_force = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    acc_cnt_nx  = acc_cnt;
    grant_vid   = 1'b0;
    grant_cpu   = 1'b0;
    capture_vid = 1'b0;
    capture_cpu = 1'b0;

    case (state)
      IDLE: begin
        if (vid_cs && !(cpu_cs && cpu_force)) begin
          grant_vid  = 1'b1;
          acc_cnt_nx = 4'd0;
          state_nx   = VID_RD;
        end else if (cpu_cs) begin
          grant_cpu  = 1'b1;
          acc_cnt_nx = 4'd0;
          state_nx   = cpu_rw ? CPU_RD : CPU_WR;
        end
      end

      VID_RD: begin
        if (acc_last) begin
          capture_vid = 1'b1;
          state_nx    = VID_ACK;
        end else begin
          acc_cnt_nx = acc_cnt + 4'd1;
        end
      end

      CPU_RD: begin
        if (acc_last) begin
          capture_cpu = 1'b1;
          state_nx    = CPU_ACK;
        end else begin
          acc_cnt_nx = acc_cnt + 4'd1;
        end
      end

      CPU_WR: begin
        if (acc_last) begin
          state_nx = WR_REC;
        end else begin
          acc_cnt_nx = acc_cnt + 4'd1;
        end
      end

      // One cycle with we_n released but ce_n, address and data still held,
      // giving the SRAM data hold time after the we_n rising edge.
      WR_REC: state_nx = CPU_ACK;

      // Leaving the ack state only once cs is low means a requester that keeps
      // cs high cannot be granted a second time for the same request.
      VID_ACK: if (!vid_cs) state_nx = IDLE;
      CPU_ACK: if (!cpu_cs) state_nx = IDLE;

      default: state_nx = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. Strobes are decoded from the next state and
  // registered, so they change only on clock edges and never glitch.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc_cnt      <= 4'd0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_dq_oe   <= 1'b0;
      sram_addr    <= '0;
      sram_dq_o    <= 8'h00;
      vid_data     <= 8'h00;
      cpu_do       <= 8'h00;
      vid_complete <= 1'b0;
      cpu_ack      <= 1'b0;
    end else begin
      state        <= state_nx;
      acc_cnt      <= acc_cnt_nx;
      sram_ce_n    <= !(state_nx == VID_RD || state_nx == CPU_RD ||
                        state_nx == CPU_WR || state_nx == WR_REC);
      sram_oe_n    <= !(state_nx == VID_RD || state_nx == CPU_RD);
      sram_we_n    <= !(state_nx == CPU_WR);
      sram_dq_oe   <= (state_nx == CPU_WR || state_nx == WR_REC);
      vid_complete <= (state_nx == VID_ACK);
      cpu_ack      <= (state_nx == CPU_ACK);

      if (grant_vid) begin
        sram_addr <= vid_addr[ADDR_W-1:0];
      end
      if (grant_cpu) begin
        sram_addr <= cpu_addr[ADDR_W-1:0];
        sram_dq_o <= cpu_di;
      end
      if (capture_vid) begin
        vid_data <= sram_dq_i;
      end
      if (capture_cpu) begin
        cpu_do <= sram_dq_i;
      end
    end
  end

endmodule
`default_nettype wire
